// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared constants and types for the pipeline execution sequencer.
//   OPCODE_BITS  : width of the instruction opcode field
//   HALT_OPCODE  : opcode that terminates execution
//   PIPE_DEPTH   : pipeline stage count; the drain lasts PIPE_DEPTH-1 cycles
//   CNT_BITS     : width of the executed-cycle counter
//   cmdCode_t    : debug/host command codes
//   prcState_t   : sequencer states
package pipeline_run_ctrl_pkg;

    localparam int unsigned OPCODE_BITS = 6;
    localparam logic [OPCODE_BITS-1:0] HALT_OPCODE = 6'b111111;
    localparam int unsigned PIPE_DEPTH = 5;
    localparam int unsigned CNT_BITS = 32;
    localparam int unsigned DRAIN_BITS = $clog2(PIPE_DEPTH);

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_STOP = 2'b11
    } cmdCode_t;

    typedef enum logic [2:0] {
        PRC_IDLE,
        PRC_RUN,
        PRC_STEP,
        PRC_DRAIN,
        PRC_HALTED
    } prcState_t;

endpackage

// File: rtl/pipeline_run_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value instead of wrapping.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset, clears the count
//   i_inc   : increment request for this edge
//   o_count : current count (WIDTH bits)
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_count <= '0;
        end else if (i_inc && (o_count != '1)) begin
            o_count <= o_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: execution sequencer for the 5-stage pipeline.
// Gates PC / pipeline-register enables from run, step and stop commands,
// freezes the PC on a fetched HALT and drains the pipe before reporting done.
//   i_clk, i_rst_n           : clock and synchronous active-low reset
//   i_cmd_valid, i_cmd       : command strobe and code (NOP/RUN/STEP/STOP)
//   o_cmd_ready              : command accepted this cycle when valid
//   i_if_valid, i_if_opcode  : fetch-stage instruction validity and opcode
//   o_pc_enable              : PC update enable (combinational)
//   o_pipe_enable            : pipeline register enable (combinational)
//   o_flush                  : bubble into IF/ID (combinational)
//   o_busy, o_halted, o_done : registered status; o_done pulses once on halt
//   o_cycle_count            : saturating count of enabled cycles
// Optional macro PIPE_CTRL_BREAKPOINT_EN adds i_bp_enable, i_bp_addr, i_pc
// and the registered pulse o_bp_hit; a breakpoint stops RUN before the
// matching instruction executes. STEP ignores breakpoints.
module pipeline_run_ctrl
    import pipeline_run_ctrl_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_cmd_valid,
    input  logic [1:0]             i_cmd,
    output logic                   o_cmd_ready,
    input  logic                   i_if_valid,
    input  logic [OPCODE_BITS-1:0] i_if_opcode,
`ifdef PIPE_CTRL_BREAKPOINT_EN
    input  logic                   i_bp_enable,
    input  logic [31:0]            i_bp_addr,
    input  logic [31:0]            i_pc,
    output logic                   o_bp_hit,
`endif
    output logic                   o_pc_enable,
    output logic                   o_pipe_enable,
    output logic                   o_flush,
    output logic                   o_busy,
    output logic                   o_halted,
    output logic                   o_done,
    output logic [CNT_BITS-1:0]    o_cycle_count
);

    prcState_t             state;
    prcState_t             nextState;
    logic [DRAIN_BITS-1:0] drainCnt;
    logic                  haltSeen;
    logic                  cmdAccept;
    logic                  bpStall;

    assign haltSeen  = i_if_valid && (i_if_opcode == HALT_OPCODE);
    assign cmdAccept = i_cmd_valid && o_cmd_ready;

`ifdef PIPE_CTRL_BREAKPOINT_EN
    // HALT takes precedence so the drain still starts on a halting breakpoint.
    assign bpStall = (state == PRC_RUN) && i_bp_enable && (i_pc == i_bp_addr) && !haltSeen;
`else
    assign bpStall = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= PRC_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            PRC_IDLE: begin
                if (cmdAccept && (i_cmd == CMD_RUN)) begin
                    nextState = PRC_RUN;
                end else if (cmdAccept && (i_cmd == CMD_STEP)) begin
                    nextState = PRC_STEP;
                end
            end
            PRC_RUN: begin
                // A HALT in the same cycle as STOP wins; the STOP is dropped.
                if (haltSeen) begin
                    nextState = PRC_DRAIN;
                end else if (bpStall || (cmdAccept && (i_cmd == CMD_STOP))) begin
                    nextState = PRC_IDLE;
                end
            end
            PRC_STEP:   nextState = haltSeen ? PRC_DRAIN : PRC_IDLE;
            PRC_DRAIN:  nextState = (drainCnt == '0) ? PRC_HALTED : PRC_DRAIN;
            PRC_HALTED: nextState = PRC_HALTED;
            default:    nextState = PRC_IDLE;
        endcase
    end

    always_comb begin
        o_pc_enable   = 1'b0;
        o_pipe_enable = 1'b0;
        o_flush       = 1'b0;
        o_cmd_ready   = 1'b0;
        unique case (state)
            PRC_IDLE: o_cmd_ready = 1'b1;
            PRC_RUN: begin
                o_cmd_ready   = 1'b1;
                o_pipe_enable = !bpStall;
                o_pc_enable   = !haltSeen && !bpStall;
            end
            PRC_STEP: begin
                o_pipe_enable = 1'b1;
                o_pc_enable   = !haltSeen;
            end
            PRC_DRAIN: begin
                o_pipe_enable = 1'b1;
                o_flush       = 1'b1;
            end
            default: ;
        endcase
    end

    // Loaded with PIPE_DEPTH-2 on entry so DRAIN occupies PIPE_DEPTH-1 cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            drainCnt <= '0;
        end else if ((state != PRC_DRAIN) && (nextState == PRC_DRAIN)) begin
            drainCnt <= DRAIN_BITS'(PIPE_DEPTH - 2);
        end else if ((state == PRC_DRAIN) && (drainCnt != '0)) begin
            drainCnt <= drainCnt - DRAIN_BITS'(1);
        end
    end

    // Status flops are fed from nextState so they line up with the state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_busy   <= 1'b0;
            o_halted <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_busy   <= (nextState == PRC_RUN) || (nextState == PRC_STEP) ||
                        (nextState == PRC_DRAIN);
            o_halted <= (nextState == PRC_HALTED);
            o_done   <= (nextState == PRC_HALTED) && (state != PRC_HALTED);
        end
    end

`ifdef PIPE_CTRL_BREAKPOINT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_bp_hit <= 1'b0;
        end else begin
            o_bp_hit <= bpStall;
        end
    end
`endif

    sat_counter #(
        .WIDTH(CNT_BITS)
    ) cycleCounter (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_inc  (o_pipe_enable),
        .o_count(o_cycle_count)
    );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
module tb_pipeline_run_ctrl;

    localparam logic [5:0] HALT_OP   = 6'b111111;
    localparam int unsigned DRAIN_LEN = 4;
    localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_STOP = 2'b11;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        cmdValid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        cmdReady;
    logic        ifValid = 1'b0;
    logic [5:0]  ifOpcode = '0;
    logic        pcEnable, pipeEnable, flush, busy, halted, done;
    logic [31:0] cycleCount;
`ifdef PIPE_CTRL_BREAKPOINT_EN
    logic        bpEnable = 1'b0;
    logic [31:0] bpAddr = '0;
    logic [31:0] pcBus = '0;
    logic        bpHit;
    logic [31:0] benchPc = '0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: abstract execution status, not the DUT's state machine.
    bit          mRunning, mStepping, mHalted, mDone, mBpHit;
    int unsigned mDrainLeft;
    logic [31:0] mCount;
    bit          ePipe, ePc, eFlush, eReady;

    pipeline_run_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_cmd_valid  (cmdValid),
        .i_cmd        (cmd),
        .o_cmd_ready  (cmdReady),
        .i_if_valid   (ifValid),
        .i_if_opcode  (ifOpcode),
`ifdef PIPE_CTRL_BREAKPOINT_EN
        .i_bp_enable  (bpEnable),
        .i_bp_addr    (bpAddr),
        .i_pc         (pcBus),
        .o_bp_hit     (bpHit),
`endif
        .o_pc_enable  (pcEnable),
        .o_pipe_enable(pipeEnable),
        .o_flush      (flush),
        .o_busy       (busy),
        .o_halted     (halted),
        .o_done       (done),
        .o_cycle_count(cycleCount)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit modelHalt();
        return ifValid && (ifOpcode == HALT_OP);
    endfunction

    function automatic bit modelBp();
`ifdef PIPE_CTRL_BREAKPOINT_EN
        return mRunning && bpEnable && (pcBus == bpAddr) && !modelHalt();
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit expBusy();
        return mRunning || mStepping || (mDrainLeft > 0);
    endfunction

    task automatic predictComb();
        ePipe = 0; ePc = 0; eFlush = 0; eReady = 0;
        if (mDrainLeft > 0) begin
            ePipe = 1; eFlush = 1;
        end else if (mHalted) begin
        end else if (mStepping) begin
            ePipe = 1; ePc = !modelHalt();
        end else if (mRunning) begin
            eReady = 1;
            ePipe = !modelBp(); ePc = !modelHalt() && !modelBp();
        end else begin
            eReady = 1;
        end
    endtask

    task automatic modelReset();
        mRunning = 0; mStepping = 0; mHalted = 0; mDone = 0; mBpHit = 0;
        mDrainLeft = 0; mCount = '0;
    endtask

    task automatic tick();
        bit h, bp, acc;
        predictComb();
        @(posedge clk);
        if (!rstN) begin
            modelReset();
        end else begin
            h = modelHalt(); bp = modelBp(); acc = cmdValid && eReady;
            if (ePipe && (mCount != 32'hFFFF_FFFF)) mCount = mCount + 1;
`ifdef PIPE_CTRL_BREAKPOINT_EN
            if (ePc) benchPc = benchPc + 4;
`endif
            mDone = 0; mBpHit = 0;
            if (mDrainLeft > 0) begin
                mDrainLeft = mDrainLeft - 1;
                if (mDrainLeft == 0) begin mHalted = 1; mDone = 1; end
            end else if (mHalted) begin
            end else if (mStepping) begin
                mStepping = 0;
                if (h) mDrainLeft = DRAIN_LEN;
            end else if (mRunning) begin
                if (h) begin mRunning = 0; mDrainLeft = DRAIN_LEN; end
                else if (bp) begin mRunning = 0; mBpHit = 1; end
                else if (acc && cmd == C_STOP) mRunning = 0;
            end else if (acc && cmd == C_RUN) begin
                mRunning = 1;
            end else if (acc && cmd == C_STEP) begin
                mStepping = 1;
            end
        end
        #1;
`ifdef PIPE_CTRL_BREAKPOINT_EN
        pcBus = benchPc;
`endif
    endtask

    task automatic drive(bit v, logic [1:0] c, bit iv, logic [5:0] op);
        cmdValid = v; cmd = c; ifValid = iv; ifOpcode = op;
        #1;
        predictComb();
    endtask

    task automatic doReset();
        rstN = 0;
        drive(0, C_NOP, 0, 6'd0);
        tick();
        tick();
        rstN = 1;
    endtask

    function automatic logic [5:0] nonHalt();
        return 6'($urandom_range(0, 62));
    endfunction

    task test_reset();
        doReset();
        drive(0, C_NOP, 0, 6'd0);
        vectors++; if (pipeEnable !== 1'b0 || pcEnable !== 1'b0 || flush !== 1'b0) begin
            miscompares++; $display("FAIL reset_enables got pipe=%b pc=%b flush=%b exp 0 0 0", pipeEnable, pcEnable, flush); end
        vectors++; if (busy !== 1'b0 || halted !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL reset_status got busy=%b halted=%b done=%b exp 0 0 0", busy, halted, done); end
        vectors++; if (cycleCount !== 32'd0) begin
            miscompares++; $display("FAIL reset_count got %0d exp 0", cycleCount); end
        vectors++; if (cmdReady !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready got %b exp 1", cmdReady); end
    endtask

    task test_run_halt();
        int flushCycles = 0;
        int donePulses = 0;
        bit pcInHalt = 1'b1;
        doReset();
        drive(1, C_RUN, 0, 6'd0);
        tick();
        for (int i = 1; i <= 4; i++) begin
            drive(0, C_NOP, 1, (i == 4) ? HALT_OP : nonHalt());
            vectors++; if (pipeEnable !== ePipe || pcEnable !== ePc) begin
                miscompares++; $display("FAIL run_halt_fetch%0d got pipe=%b pc=%b exp %b %b", i, pipeEnable, pcEnable, ePipe, ePc); end
            if (i == 4) pcInHalt = pcEnable;
            tick();
        end
        vectors++; if (pcInHalt !== 1'b0) begin
            miscompares++; $display("FAIL run_halt_pc_in_halt got %b exp 0", pcInHalt); end
        for (int n = 0; n < 12 && halted !== 1'b1; n++) begin
            drive(0, C_NOP, 0, 6'd0);
            vectors++; if (flush !== eFlush || pipeEnable !== ePipe || pcEnable !== ePc || cmdReady !== eReady) begin
                miscompares++; $display("FAIL run_halt_drain got flush=%b pipe=%b pc=%b rdy=%b exp %b %b %b %b",
                                        flush, pipeEnable, pcEnable, cmdReady, eFlush, ePipe, ePc, eReady); end
            if (flush === 1'b1) flushCycles++;
            tick();
            if (done === 1'b1) donePulses++;
        end
        for (int n = 0; n < 3; n++) begin
            drive(1, C_RUN, 0, 6'd0);
            tick();
            if (done === 1'b1) donePulses++;
        end
        vectors++; if (flushCycles != 4) begin
            miscompares++; $display("FAIL run_halt_flush_cycles got %0d exp 4", flushCycles); end
        vectors++; if (donePulses != 1) begin
            miscompares++; $display("FAIL run_halt_done_pulses got %0d exp 1", donePulses); end
        vectors++; if (cycleCount !== 32'd8 || halted !== 1'b1) begin
            miscompares++; $display("FAIL run_halt_final got count=%0d halted=%b exp 8 1", cycleCount, halted); end
    endtask

    task test_step();
        int enabledCycles;
        doReset();
        for (int s = 0; s < 3; s++) begin
            enabledCycles = 0;
            drive(1, C_STEP, 1, nonHalt());
            if (pipeEnable === 1'b1) enabledCycles++;
            tick();
            for (int k = 0; k < 3; k++) begin
                drive(0, C_NOP, 1, nonHalt());
                if (k == 0) begin
                    vectors++; if (cmdReady !== 1'b0 || busy !== 1'b1) begin
                        miscompares++; $display("FAIL step_ready got rdy=%b busy=%b exp 0 1", cmdReady, busy); end
                end
                if (pipeEnable === 1'b1) enabledCycles++;
                tick();
            end
            vectors++; if (enabledCycles != 1) begin
                miscompares++; $display("FAIL step_enabled_cycles got %0d exp 1", enabledCycles); end
        end
        vectors++; if (cycleCount !== 32'd3 || busy !== 1'b0 || cmdReady !== 1'b1) begin
            miscompares++; $display("FAIL step_final got count=%0d busy=%b rdy=%b exp 3 0 1", cycleCount, busy, cmdReady); end
    endtask

    task test_run_stop();
        doReset();
        drive(1, C_RUN, 0, 6'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, C_NOP, 1, nonHalt());
            tick();
        end
        drive(1, C_STOP, 1, nonHalt());
        vectors++; if (pipeEnable !== 1'b1) begin
            miscompares++; $display("FAIL stop_cycle_exec got pipe=%b exp 1", pipeEnable); end
        tick();
        drive(0, C_NOP, 1, nonHalt());
        vectors++; if (pipeEnable !== 1'b0 || busy !== 1'b0 || cycleCount !== 32'd11) begin
            miscompares++; $display("FAIL stop_idle got pipe=%b busy=%b count=%0d exp 0 0 11", pipeEnable, busy, cycleCount); end
        drive(1, C_RUN, 1, nonHalt());
        tick();
        drive(0, C_NOP, 1, nonHalt());
        vectors++; if (pipeEnable !== 1'b1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL stop_resume got pipe=%b busy=%b exp 1 1", pipeEnable, busy); end
    endtask

    task test_stop_vs_halt();
        doReset();
        drive(1, C_RUN, 0, 6'd0);
        tick();
        drive(0, C_NOP, 1, nonHalt());
        tick();
        drive(1, C_STOP, 1, HALT_OP);
        tick();
        drive(0, C_NOP, 0, 6'd0);
        vectors++; if (flush !== 1'b1 || busy !== 1'b1 || cmdReady !== 1'b0) begin
            miscompares++; $display("FAIL stop_halt_drain got flush=%b busy=%b rdy=%b exp 1 1 0", flush, busy, cmdReady); end
        for (int n = 0; n < 8; n++) tick();
        vectors++; if (halted !== 1'b1 || cycleCount !== mCount) begin
            miscompares++; $display("FAIL stop_halt_final got halted=%b count=%0d exp 1 %0d", halted, cycleCount, mCount); end
    endtask

    task test_reset_in_drain();
        int donePulses = 0;
        doReset();
        drive(1, C_RUN, 0, 6'd0);
        tick();
        drive(0, C_NOP, 1, HALT_OP);
        tick();
        drive(0, C_NOP, 0, 6'd0);
        tick();
        rstN = 0;
        drive(0, C_NOP, 0, 6'd0);
        vectors++; if (flush !== 1'b1) begin
            miscompares++; $display("FAIL rst_drain_pre got flush=%b exp 1", flush); end
        tick();
        rstN = 1;
        drive(0, C_NOP, 0, 6'd0);
        vectors++; if (pipeEnable !== 1'b0 || pcEnable !== 1'b0 || flush !== 1'b0 || cmdReady !== 1'b1) begin
            miscompares++; $display("FAIL rst_drain_enables got pipe=%b pc=%b flush=%b rdy=%b exp 0 0 0 1",
                                    pipeEnable, pcEnable, flush, cmdReady); end
        vectors++; if (busy !== 1'b0 || halted !== 1'b0 || done !== 1'b0 || cycleCount !== 32'd0) begin
            miscompares++; $display("FAIL rst_drain_status got busy=%b halted=%b done=%b count=%0d exp 0 0 0 0",
                                    busy, halted, done, cycleCount); end
        for (int n = 0; n < 6; n++) begin
            tick();
            if (done === 1'b1) donePulses++;
        end
        vectors++; if (donePulses != 0 || halted !== 1'b0) begin
            miscompares++; $display("FAIL rst_drain_no_done got pulses=%0d halted=%b exp 0 0", donePulses, halted); end
    endtask

`ifdef PIPE_CTRL_BREAKPOINT_EN
    task test_breakpoint();
        int hits = 0;
        doReset();
        benchPc = '0; pcBus = '0; bpEnable = 1; bpAddr = 32'h10;
        drive(1, C_RUN, 1, nonHalt());
        tick();
        for (int n = 0; n < 10 && busy === 1'b1; n++) begin
            drive(0, C_NOP, 1, nonHalt());
            vectors++; if (pipeEnable !== ePipe || pcEnable !== ePc) begin
                miscompares++; $display("FAIL bp_run got pipe=%b pc=%b exp %b %b", pipeEnable, pcEnable, ePipe, ePc); end
            tick();
            if (bpHit === 1'b1) hits++;
        end
        vectors++; if (hits != 1 || busy !== 1'b0 || pcBus !== 32'h10 || cycleCount !== 32'd4) begin
            miscompares++; $display("FAIL bp_stall got hits=%0d busy=%b pc=%h count=%0d exp 1 0 10 4", hits, busy, pcBus, cycleCount); end
        drive(1, C_STEP, 1, nonHalt());
        tick();
        drive(0, C_NOP, 1, nonHalt());
        vectors++; if (pipeEnable !== 1'b1 || pcEnable !== 1'b1) begin
            miscompares++; $display("FAIL bp_step got pipe=%b pc=%b exp 1 1", pipeEnable, pcEnable); end
        tick();
        vectors++; if (pcBus !== 32'h14 || bpHit !== 1'b0) begin
            miscompares++; $display("FAIL bp_step_after got pc=%h hit=%b exp 14 0", pcBus, bpHit); end
        bpEnable = 0;
    endtask
`endif

    task test_random();
        bit v;
        logic [1:0] c;
        bit iv;
        logic [5:0] op;
        doReset();
        for (int n = 0; n < 400; n++) begin
            rstN = ($urandom_range(0, 59) != 0);
            v  = $urandom_range(0, 1);
            c  = 2'($urandom_range(0, 3));
            iv = ($urandom_range(0, 3) != 0);
            op = ($urandom_range(0, 11) == 0) ? HALT_OP : nonHalt();
            drive(v, c, iv, op);
            vectors++; if (pipeEnable !== ePipe || pcEnable !== ePc || flush !== eFlush || cmdReady !== eReady) begin
                miscompares++; $display("FAIL random_comb[%0d] got pipe=%b pc=%b flush=%b rdy=%b exp %b %b %b %b",
                                        n, pipeEnable, pcEnable, flush, cmdReady, ePipe, ePc, eFlush, eReady); end
            tick();
            vectors++; if (busy !== expBusy() || halted !== mHalted || done !== mDone || cycleCount !== mCount) begin
                miscompares++; $display("FAIL random_regs[%0d] got busy=%b halted=%b done=%b count=%0d exp %b %b %b %0d",
                                        n, busy, halted, done, cycleCount, expBusy(), mHalted, mDone, mCount); end
        end
        rstN = 1;
    endtask

    initial begin
        modelReset();
        test_reset();
        test_run_halt();
        test_step();
        test_run_stop();
        test_stop_vs_halt();
        test_reset_in_drain();
`ifdef PIPE_CTRL_BREAKPOINT_EN
        test_breakpoint();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
